// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage register with a main+skid pair, so in_ready comes from a register.
// Optional stall/bubble performance counters are compiled in with `define PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int PAYLOAD_W      = 71,
  parameter bit CLEAR_ON_FLUSH = 1'b0,
  parameter int CNT_W          = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
`endif
);

  logic                 r_main_valid;
  logic                 r_skid_valid;
  logic [PAYLOAD_W-1:0] r_main;
  logic [PAYLOAD_W-1:0] r_skid;

  logic w_accept;
  logic w_pop;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_payload = r_main;

  assign w_accept = in_valid & ~r_skid_valid;
  assign w_pop    = r_main_valid & out_ready;

  // accept is impossible while FULL, so only EMPTY/ONE reach the in->main path
  assign w_load_main_in   = w_accept & (~r_main_valid | w_pop);
  assign w_load_main_skid = r_skid_valid & w_pop;
  assign w_load_skid      = w_accept & r_main_valid & ~w_pop;

  assign w_main_valid_nxt = w_accept | r_skid_valid | (r_main_valid & ~w_pop);
  assign w_skid_valid_nxt = w_load_skid | (r_skid_valid & ~w_pop);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
    end
  end

  // payload registers only toggle when a valid bit is being loaded
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) begin
        r_main <= '0;
        r_skid <= '0;
      end
    end else begin
      if (w_load_main_in) begin
        r_main <= in_payload;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= in_payload;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_stall;
  logic             w_bubble;

  assign w_stall    = r_main_valid & ~out_ready;
  assign w_bubble   = ~r_main_valid;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // saturating counters; flush cycles still count
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule
